// File: rtl/tmr_pkg.sv
// Shared definitions for the shared microsecond delay scheduler:
// FSM encoding, default widths and the round-robin pick helper.
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF = 20;
  localparam int unsigned US_PER_S  = 1_000_000;
  localparam int unsigned MAX_REQ   = 8;

  // One-hot winner, searching from last+1 upward and wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input int unsigned        last,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] oh;
    logic               found;
    int unsigned        idx;
    logic [2:0]         sel;
    oh    = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      sel = idx[2:0];
      if (k <= n && !found && req[sel]) begin
        oh[sel] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/tmr_core.sv
// Loadable down-counter that stops at zero; the shared delay resource.
module tmr_core #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             safe_clk,
  input  logic             safe_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge safe_clk) begin
    if (safe_reset)       count <= '0;
    else if (load)        count <= load_val;
    else if (en && !zero) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tmr_share_ctrl.sv
// Round-robin scheduler sharing one delay counter among N_REQ requesters;
// grants one at a time, runs the delay to expiry and pulses done.
module tmr_share_ctrl
  import tmr_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   safe_clk,
  input  logic                   safe_reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_delay,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cur_count
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_t           state, state_nx;
  logic [IW-1:0]    last, last_nx, gnt_idx;
  logic [N_REQ-1:0] pick_oh, gnt_nx, done_nx;
  logic [CNT_W-1:0] load_val;
  logic             busy_nx, load, en, zero, req_own;

  always_comb pick_oh = N_REQ'(rr_pick(MAX_REQ'(req), 32'(last), N_REQ));

  always_comb begin
    load_val = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (pick_oh[i]) load_val = req_delay[i*CNT_W +: CNT_W];
  end

  // The owner index is recovered from the registered one-hot grant.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (gnt[i]) gnt_idx = IW'(i);
  end

  assign req_own = |(req & gnt);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    done_nx  = '0;
    busy_nx  = busy;
    last_nx  = last;
    load     = 1'b0;
    en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nx = ST_RUN;
          gnt_nx   = pick_oh;
          busy_nx  = 1'b1;
          load     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!req_own) begin
          state_nx = ST_IDLE;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
          last_nx  = gnt_idx;
        end else if (zero) begin
          state_nx = ST_DONE;
          done_nx  = gnt;
        end else begin
          en = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        last_nx  = gnt_idx;
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge safe_clk) begin
    if (safe_reset) begin
      state <= ST_IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      last  <= IW'(N_REQ - 1);
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      done  <= done_nx;
      busy  <= busy_nx;
      last  <= last_nx;
    end
  end

  tmr_core #(.CNT_W(CNT_W)) u_core (
    .safe_clk   (safe_clk),
    .safe_reset (safe_reset),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .count      (cur_count),
    .zero       (zero)
  );

endmodule
